// File: rtl/bsg_rr_mux_sched_pkg.sv
// bsg_rr_mux_sched_pkg: shared lock-state type and index-width helper for the
// round-robin mux scheduler.
package bsg_rr_mux_sched_pkg;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_rr_mux_sched_arb.sv
// bsg_rr_mux_sched_arb: one-hot round-robin grant starting at ptr+1, restricted
// to the requesters enabled by mask_i.
module bsg_rr_mux_sched_arb
    import bsg_rr_mux_sched_pkg::*;
#(
    parameter int els_p = 4,
    localparam int idx_w = idx_width(els_p)
) (
    input  logic [els_p-1:0] req_i,
    input  logic [idx_w-1:0] ptr_i,
    input  logic [els_p-1:0] mask_i,
    output logic [els_p-1:0] grant_o
);

    logic [els_p-1:0] cand;
    logic [idx_w-1:0] k;
    logic             found;

    assign cand = req_i & mask_i;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 1; i <= els_p; i++) begin
            k = idx_w'((int'(ptr_i) + i) % els_p);
            if (!found && cand[k]) begin
                grant_o[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_rr_mux_sched.sv
// bsg_rr_mux_sched: round-robin N:1 mux into a one-entry output register.
// Define BSG_RR_MUX_SCHED_LOCK_EN to hold the grant on one requester until its last beat.
module bsg_rr_mux_sched
    import bsg_rr_mux_sched_pkg::*;
#(
    parameter int els_p   = 4,
    parameter int width_p = 16,
    localparam int idx_w  = idx_width(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         last_i,
    output logic [els_p-1:0]         yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     last_o,
    input  logic                     ready_i
);

    logic [els_p-1:0]   grant, mask;
    logic [idx_w-1:0]   ptr_q, ptr_d, gidx;
    logic               v_q, v_d, last_q, last_d;
    logic               load, accept, sel_last;
    logic [width_p-1:0] data_q, data_d, sel_data;
`ifdef BSG_RR_MUX_SCHED_LOCK_EN
    lock_state_e        state_q, state_d;
    logic [idx_w-1:0]   owner_q, owner_d;
`endif

    assign load = ~v_q | ready_i;

`ifdef BSG_RR_MUX_SCHED_LOCK_EN
    assign mask = (state_q == LOCKED) ? (els_p'(1) << owner_q) : '1;
`else
    assign mask = '1;
`endif

    bsg_rr_mux_sched_arb #(.els_p(els_p)) arb (
        .req_i  (v_i),
        .ptr_i  (ptr_q),
        .mask_i (mask),
        .grant_o(grant)
    );

    assign yumi_o = reset_i ? '0 : (grant & {els_p{load}});
    assign accept = |yumi_o;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        gidx     = '0;
        for (int i = 0; i < els_p; i++) begin
            sel_data = sel_data | (data_i[i*width_p +: width_p] & {width_p{grant[i]}});
            sel_last = sel_last | (last_i[i] & grant[i]);
            if (grant[i]) gidx = idx_w'(i);
        end
    end

    always_comb begin
        v_d    = accept | (v_q & ~ready_i);
        data_d = accept ? sel_data : data_q;
        last_d = accept ? sel_last : last_q;
`ifdef BSG_RR_MUX_SCHED_LOCK_EN
        ptr_d   = (accept && sel_last) ? gidx : ptr_q;
        state_d = state_q;
        owner_d = owner_q;
        if (accept && state_q == IDLE && !sel_last) begin
            state_d = LOCKED;
            owner_d = gidx;
        end else if (accept && sel_last) begin
            state_d = IDLE;
        end
`else
        ptr_d = accept ? gidx : ptr_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q     <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ptr_q   <= idx_w'(els_p - 1);
`ifdef BSG_RR_MUX_SCHED_LOCK_EN
            state_q <= IDLE;
            owner_q <= '0;
`endif
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
`ifdef BSG_RR_MUX_SCHED_LOCK_EN
            state_q <= state_d;
            owner_q <= owner_d;
`endif
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign last_o = last_q;

endmodule

// File: tb/tb_bsg_rr_mux_sched.sv
// tb_bsg_rr_mux_sched: random and directed stimulus checked every cycle against
// a behavioural model of the round-robin scheduler.
module tb_bsg_rr_mux_sched;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic [N-1:0]   v_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   last_i = '0;
    logic           ready_i = 1'b1;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic           last_o;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int           mptr = N - 1;
    int           lock_own = -1;
    logic         mv = 1'b0;
    logic [W-1:0] md = '0;
    logic         ml = 1'b0;

    bsg_rr_mux_sched #(.els_p(N), .width_p(W)) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .v_i    (v_i),
        .data_i (data_i),
        .last_i (last_i),
        .yumi_o (yumi_o),
        .v_o    (v_o),
        .data_o (data_o),
        .last_o (last_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Which requester the spec says is accepted this cycle, or -1.
    function automatic int exp_grant();
        if (reset_i) return -1;
        if (mv && !ready_i) return -1;
        if (lock_own >= 0) return v_i[lock_own] ? lock_own : -1;
        for (int j = 1; j <= N; j++)
            if (v_i[(mptr + j) % N]) return (mptr + j) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = exp_grant();
        if (reset_i) begin
            mv = 1'b0; md = '0; ml = 1'b0; mptr = N - 1; lock_own = -1;
        end else if (g >= 0) begin
            mv = 1'b1;
            md = data_i[g*W +: W];
            ml = last_i[g];
`ifdef BSG_RR_MUX_SCHED_LOCK_EN
            if (last_i[g]) begin
                lock_own = -1;
                mptr = g;
            end else if (lock_own < 0) begin
                lock_own = g;
            end
`else
            mptr = g;
`endif
        end else if (ready_i) begin
            mv = 1'b0;
        end
    end

    always @(negedge clk) begin
        int g;
        if (chk_en) begin
            g = exp_grant();
            lit("model_yumi", 32'(yumi_o), (g < 0) ? 32'd0 : (32'd1 << g));
            lit("model_v_o", 32'(v_o), 32'(mv));
            lit("model_data_o", 32'(data_o), 32'(md));
            lit("model_last_o", 32'(last_o), 32'(ml));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        v_i = '0;
        tick();
        reset_i = 1'b0;
    endtask

    logic [N-1:0] seq31 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] seq34 [4];
    logic [N-1:0] l1_34 [4] = '{4'b0001, 4'b0001, 4'b0011, 4'b0001};

    initial begin
`ifdef BSG_RR_MUX_SCHED_LOCK_EN
        seq34 = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
        seq34 = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        tick();
        tick();
        reset_i = 1'b0;
        chk_en = 1'b1;
        #1;
        lit("reset_v_o", 32'(v_o), 32'd0);
        lit("reset_data_o", 32'(data_o), 32'd0);

        // reset priority sweep
        for (int i = 0; i < N; i++) data_i[i*W +: W] = 16'h1000 + 16'(i);
        v_i = 4'b1111; last_i = 4'b1111; ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            lit("rr_yumi", 32'(yumi_o), 32'(seq31[c]));
            if (c > 0) lit("rr_data", 32'(data_o), 32'h1000 + 32'($clog2(seq31[c-1])));
            tick();
        end

        // idle drain
        do_reset();
        v_i = 4'b0100; data_i[2*W +: W] = 16'h1234;
        #1; lit("drain_yumi", 32'(yumi_o), 32'b0100);
        tick(); v_i = '0;
        #1; lit("drain_v1", 32'(v_o), 32'd1); lit("drain_d1", 32'(data_o), 32'h1234);
        tick();
        #1; lit("drain_v0", 32'(v_o), 32'd0); lit("drain_hold", 32'(data_o), 32'h1234);
        tick(); v_i = 4'b1001;
        #1; lit("drain_next", 32'(yumi_o), 32'b1000);
        tick();

        // backpressure
        do_reset();
        v_i = 4'b0001; data_i[0 +: W] = 16'hA5A5; ready_i = 1'b0;
        #1; lit("bp_load", 32'(yumi_o), 32'b0001);
        tick(); v_i = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            lit("bp_yumi", 32'(yumi_o), 32'd0);
            lit("bp_data", 32'(data_o), 32'hA5A5);
            lit("bp_v", 32'(v_o), 32'd1);
            tick();
        end
        ready_i = 1'b1;
        #1; lit("bp_release", 32'(yumi_o), 32'b0100);
        tick();

        // packet lock vs interleave
        do_reset();
        v_i = 4'b0010; last_i = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) v_i = 4'b0011;
            last_i = l1_34[c];
            if (c == 0) last_i = 4'b0000;
            #1; lit("pkt_yumi", 32'(yumi_o), 32'(seq34[c]));
            tick();
        end

        // reset mid-packet
        do_reset();
        v_i = 4'b0010; last_i = 4'b0000;
        #1; lit("mid_b1", 32'(yumi_o), 32'b0010);
        tick(); v_i = 4'b0011;
        tick(); reset_i = 1'b1;
        #1; lit("mid_rst_yumi", 32'(yumi_o), 32'd0);
        tick(); reset_i = 1'b0;
        #1; lit("mid_v_o", 32'(v_o), 32'd0); lit("mid_first", 32'(yumi_o), 32'b0001);
        tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            reset_i = ($urandom % 64) == 0;
            v_i = N'($urandom);
            data_i = {$urandom, $urandom};
            last_i = N'($urandom);
            ready_i = ($urandom % 4) != 0;
            tick();
        end
        reset_i = 1'b0;
        v_i = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_rr_mux_sched.md
BSG_RR_MUX_SCHED -- requirements
Module: bsg_rr_mux_sched

Interface
REQ-001 SHALL have parameter els_p, default 4, giving the number of requesters (>=1).
REQ-002 SHALL have parameter width_p, default 16, giving the data width per requester.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port v_i, input, els_p bits: per-requester valid.
REQ-006 SHALL have port data_i, input, els_p*width_p bits: requester i occupies bits [i*width_p +: width_p].
REQ-007 SHALL have port last_i, input, els_p bits: per-requester end-of-packet flag.
REQ-008 SHALL have port yumi_o, output, els_p bits: one-hot accept, combinational.
REQ-009 SHALL have port v_o, output, 1 bit: output register valid.
REQ-010 SHALL have port data_o, output, width_p bits: registered selected data.
REQ-011 SHALL have port last_o, output, 1 bit: registered selected last flag.
REQ-012 SHALL have port ready_i, input, 1 bit: downstream ready.

Function
REQ-013 SHALL compute load = ~v_o | ready_i; a beat is accepted only when load=1 and a grant exists.
REQ-014 SHALL form grant as a one-hot vector with at most one bit set, chosen round-robin.
REQ-015 SHALL start the round-robin search at index (ptr+1) mod els_p, where ptr is the last requester that completed a beat or packet.
REQ-016 SHALL set yumi_o = grant & {els_p{load}}; yumi_o SHALL NOT depend on ready_i except through load, and SHALL be 0 while reset_i=1.
REQ-017 SHALL, on an accepted beat, select data_i and last_i via a one-hot AND-OR mux driven by grant, and register them into data_o/last_o with v_o=1 on the next edge (latency 1 cycle).
REQ-018 SHALL clear v_o on the next edge when ready_i=1, v_o=1 and no beat is accepted.
REQ-019 SHALL hold data_o, last_o and v_o stable while v_o=1 and ready_i=0.
REQ-020 SHALL sustain 1 beat/cycle when ready_i is held 1 and requests are continuous.
REQ-021 SHALL, with no valid inputs, produce grant=0, leave ptr unchanged and accept nothing.
REQ-022 SHALL, for els_p=1, grant requester 0 whenever v_i[0]=1 and load=1.
REQ-023 SHALL leave data_o unchanged (not zeroed) when v_o falls.

Reset
REQ-024 SHALL, on a clock edge with reset_i=1, set v_o=0, data_o=0, last_o=0, ptr=els_p-1 (so requester 0 has first priority), and lock state=IDLE.
REQ-025 SHALL abandon any in-flight lock when reset_i is asserted mid-packet; no partial-packet state survives reset.

Configuration
REQ-026 SHALL, when macro BSG_RR_MUX_SCHED_LOCK_EN is defined, run a two-state FSM: IDLE -> LOCKED(owner=granted index) on accepting a beat with last_i=0; LOCKED -> IDLE on accepting the owner's beat with last_i=1.
REQ-027 SHALL, in LOCKED, grant only the owner (even if the owner's v_i=0 and others are valid), and update ptr only when a last_i=1 beat is accepted.
REQ-028 SHALL, when BSG_RR_MUX_SCHED_LOCK_EN is undefined, arbitrate every beat independently and update ptr on every accepted beat; last_i is passed through to last_o but has no effect on arbitration.

Structure
REQ-029 SHALL place the lock-state enum typedef (IDLE, LOCKED) in package bsg_rr_mux_sched_pkg.
REQ-030 SHALL implement round-robin grant generation in sub-module bsg_rr_mux_sched_arb (inputs: requests, ptr, lock mask; output: one-hot grant); all registers SHALL reside in the top module.

Verification (els_p=4, width_p=16)
REQ-031 SHALL cover reset priority: after reset, v_i=4'b1111 with all last_i=1 and ready_i=1 -> yumi_o sequence 0001, 0010, 0100, 1000, 0001; data_o follows one cycle later.
REQ-032 SHALL cover backpressure: v_o=1, data_o=16'hA5A5, ready_i=0 for 5 cycles with v_i=4'b0100 -> yumi_o=0 throughout and data_o held; when ready_i=1, yumi_o=0100 in that cycle.
REQ-033 SHALL cover idle drain: single beat 16'h1234 from requester 2, then v_i=0 with ready_i=1 -> v_o=1 for exactly 1 cycle, ptr=2, and the next request from requester 3 wins over requester 0.
REQ-034 SHALL cover lock (LOCK_EN defined): requester 1 sends a 3-beat packet with last on beat 3 while v_i[0]=1 -> yumi_o[0]=0 until requester 1's last beat is accepted, then requester 0 is granted.
REQ-035 SHALL cover no lock (LOCK_EN undefined): same stimulus as REQ-034 -> grants interleave 0010, 0001, 0010, 0001.
REQ-036 SHALL cover reset mid-packet: reset_i pulsed after beat 2 of a locked packet -> v_o=0, FSM=IDLE, and requester 0 is granted first afterwards.
